// File: rtl/mem_arb2_if.sv
`default_nettype none
// ============================================================================
// mem_arb2_if : request/response types and valid/ready bus for mem_arb2.
// Revision    : 1.0
// ============================================================================
package mem_arb2_pkg;

    typedef struct packed {
        logic        req_type;   // 0 = read, 1 = write
        logic [31:0] req_addr;
        logic [31:0] req_data;
        logic [3:0]  req_mask;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] resp_data;
    } mem_resp_t;

endpackage

interface mem_arb2_if;
    import mem_arb2_pkg::*;

    logic      req_valid;
    mem_req_t  req;
    logic      req_ready;
    logic      resp_valid;
    mem_resp_t resp;
    logic      resp_ready;

    modport master (
        output req_valid, req, resp_ready,
        input  req_ready, resp_valid, resp
    );

    modport slave (
        input  req_valid, req, resp_ready,
        output req_ready, resp_valid, resp
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb2.sv
`default_nettype none
// ============================================================================
// mem_arb2 : two-requester memory arbiter with in-order response routing.
//            Define MEM_ARB_RR_EN for round-robin, else port 1 has priority.
// Revision : 1.0
// ============================================================================
module mem_arb2 #(
    parameter int OT_DEPTH = 4,
    parameter int CNT_W    = $clog2(OT_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    mem_arb2_if.slave        m0,
    mem_arb2_if.slave        m1,
    mem_arb2_if.master       s,
    output logic [CNT_W-1:0] ot_cnt
);

    localparam int               PTR_W      = $clog2(OT_DEPTH);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OT_DEPTH);

    logic [OT_DEPTH-1:0] id_q, id_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic w_full;
    logic w_empty;
    logic w_any;
    logic w_gnt1;
    logic w_push;
    logic w_pop;
    logic w_head;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    // On a tie the port that did not win the previous issue is granted.
    assign w_gnt1     = m1.req_valid & (~m0.req_valid | ~last_gnt_q);
    assign last_gnt_d = w_push ? w_gnt1 : last_gnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    assign w_gnt1 = m1.req_valid;
`endif

    assign w_full  = (cnt_q == c_full_cnt);
    assign w_empty = (cnt_q == '0);
    assign w_any   = m0.req_valid | m1.req_valid;
    assign w_head  = id_q[rd_ptr_q];

    // Request path: purely combinational, no issue while full even on a pop.
    assign s.req_valid  = w_any & ~w_full;
    assign s.req        = w_gnt1 ? m1.req : m0.req;
    assign m1.req_ready = w_gnt1 & s.req_ready & ~w_full;
    assign m0.req_ready = ~w_gnt1 & m0.req_valid & s.req_ready & ~w_full;

    // Response path: steered by the oldest outstanding ID.
    assign m0.resp_valid = s.resp_valid & ~w_empty & ~w_head;
    assign m1.resp_valid = s.resp_valid & ~w_empty & w_head;
    assign m0.resp       = s.resp;
    assign m1.resp       = s.resp;
    assign s.resp_ready  = ~w_empty & (w_head ? m1.resp_ready : m0.resp_ready);

    assign w_push = s.req_valid & s.req_ready;
    assign w_pop  = s.resp_valid & s.resp_ready;
    assign ot_cnt = cnt_q;

    always_comb begin
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (w_push) begin
            id_d[wr_ptr_q] = w_gnt1;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding means the slave is out of sync.
    always_ff @(posedge clk) begin
        if (rstn) begin
            a_resp_when_empty: assert (!(s.resp_valid && w_empty));
        end
    end
`endif

endmodule
`default_nettype wire
